// File: rtl/periph_bus_master.sv
// periph_bus_master: single-outstanding initiator for the peripheral register bus.
// It accepts one read/write command on a valid/ready port and issues one req/ack bus
// transaction for it. The result is returned on a valid/ready response port. Every
// output is registered.
// Optional feature macro: BUS_TIMEOUT_EN. When it is defined, a BUSY wait counter ends
// a transaction that is never acked and flags it with rsp_err_o. When it is not defined,
// BUSY waits for ack_i with no limit and rsp_err_o stays 0.

module periph_bus_master #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_we_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [DATA_W-1:0] cmd_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              req_o,
    output logic              we_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] data_o,
    input  logic [DATA_W-1:0] data_i,
    input  logic              ack_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_s;

    logic                cmd_ready_s;
    logic                rsp_valid_s;
    logic [DATA_W-1:0]   rsp_rdata_s;
    logic                rsp_err_s;
    logic                req_s;
    logic                we_s;
    logic [ADDR_W-1:0]   addr_s;
    logic [DATA_W-1:0]   data_s;

    logic                accept_s;
    logic                rsp_done_s;
    logic                timeout_s;

    assign accept_s   = cmd_valid_i & cmd_ready_o & (state_r == ST_IDLE);
    assign rsp_done_s = rsp_valid_o & rsp_ready_i;

`ifdef BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_r;

    // Count BUSY cycles since the command was accepted, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if ((state_r == ST_BUSY) && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // The counter reads k-1 in the k-th BUSY cycle, so the give-up happens in cycle TIMEOUT_CYC.
    assign timeout_s = (state_r == ST_BUSY) && (cnt_r == CNT_W'(TIMEOUT_CYC - 1));
`else
    assign timeout_s = 1'b0;
`endif

    // State register: a synchronous active-low reset returns the FSM to IDLE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: IDLE -> BUSY on accept, BUSY -> RESP on ack/timeout, RESP -> IDLE on handshake.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = ST_BUSY;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (ack_i || timeout_s) begin
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_BUSY;
                end
            end
            ST_RESP: begin
                if (rsp_done_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output next-value logic: by default every output holds, and only the transitions listed here change it.
    always_comb begin
        cmd_ready_s = cmd_ready_o;
        rsp_valid_s = rsp_valid_o;
        rsp_rdata_s = rsp_rdata_o;
        rsp_err_s   = rsp_err_o;
        req_s       = req_o;
        we_s        = we_o;
        addr_s      = addr_o;
        data_s      = data_o;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    we_s        = cmd_we_i;
                    addr_s      = cmd_addr_i;
                    data_s      = cmd_wdata_i;
                    req_s       = 1'b1;
                    cmd_ready_s = 1'b0;
                end else begin
                    req_s       = 1'b0;
                    cmd_ready_s = 1'b1;
                end
            end
            ST_BUSY: begin
                if (ack_i) begin
                    // An ack wins over a timeout in the same cycle; data_i is only sampled here.
                    rsp_rdata_s = we_o ? {DATA_W{1'b0}} : data_i;
                    rsp_err_s   = 1'b0;
                    req_s       = 1'b0;
                    rsp_valid_s = 1'b1;
                end else if (timeout_s) begin
                    rsp_rdata_s = {DATA_W{1'b0}};
                    rsp_err_s   = 1'b1;
                    req_s       = 1'b0;
                    rsp_valid_s = 1'b1;
                end else begin
                    req_s       = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_done_s) begin
                    rsp_valid_s = 1'b0;
                    cmd_ready_s = 1'b1;
                end else begin
                    rsp_valid_s = 1'b1;
                end
            end
            default: begin
                req_s       = 1'b0;
                rsp_valid_s = 1'b0;
                cmd_ready_s = 1'b0;
            end
        endcase
    end

    // Output registers: all outputs clear on reset, which also discards any transaction in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cmd_ready_o <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= {DATA_W{1'b0}};
            rsp_err_o   <= 1'b0;
            req_o       <= 1'b0;
            we_o        <= 1'b0;
            addr_o      <= {ADDR_W{1'b0}};
            data_o      <= {DATA_W{1'b0}};
        end else begin
            cmd_ready_o <= cmd_ready_s;
            rsp_valid_o <= rsp_valid_s;
            rsp_rdata_o <= rsp_rdata_s;
            rsp_err_o   <= rsp_err_s;
            req_o       <= req_s;
            we_o        <= we_s;
            addr_o      <= addr_s;
            data_o      <= data_s;
        end
    end

endmodule

// File: tb/tb_periph_bus_master.sv
// Directed testbench for periph_bus_master. A bench-side slave keeps its own memory, and a
// reference memory that is updated from the command stream supplies the expected read data.
module tb_periph_bus_master;

    logic        clk;
    logic        rst;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_we_i;
    logic [31:0] cmd_addr_i;
    logic [31:0] cmd_wdata_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        req_o;
    logic        we_o;
    logic [31:0] addr_o;
    logic [31:0] data_o;
    logic [31:0] data_i;
    logic        ack_i;

    int n_cmp;
    int n_err;

    logic [31:0] ref_mem [16];
    logic [31:0] slv_mem [16];

    periph_bus_master #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_we_i    (cmd_we_i),
        .cmd_addr_i  (cmd_addr_i),
        .cmd_wdata_i (cmd_wdata_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o),
        .req_o       (req_o),
        .we_o        (we_o),
        .addr_o      (addr_o),
        .data_o      (data_o),
        .data_i      (data_i),
        .ack_i       (ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case a wait somewhere never ends.
    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one command. The slave acks in req cycle 'delay' (0 = first), and rsp_ready_i is held low for 'hold' cycles.
    task automatic do_cmd(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input int delay, input int hold, input string tag);
        int waited;
        logic [31:0] exp;
        waited = 0;
        while (cmd_ready_o !== 1'b1 && waited < 20) begin
            tick;
            waited++;
        end
        check_eq({tag, "_cmd_ready"}, {31'd0, cmd_ready_o}, 32'd1);
        exp = we ? 32'd0 : ref_mem[addr[5:2]];
        if (we) ref_mem[addr[5:2]] = wdata;
        rsp_ready_i = (hold == 0);
        cmd_valid_i = 1'b1;
        cmd_we_i    = we;
        cmd_addr_i  = addr;
        cmd_wdata_i = wdata;
        tick;
        cmd_valid_i = 1'b0;
        cmd_we_i    = ~we;
        cmd_addr_i  = 32'hFFFF_FFF0;
        cmd_wdata_i = 32'h0BAD_0BAD;
        for (int k = 0; k <= delay; k++) begin
            check_eq({tag, "_req"}, {31'd0, req_o}, 32'd1);
            check_eq({tag, "_we"}, {31'd0, we_o}, {31'd0, we});
            check_eq({tag, "_addr"}, addr_o, addr);
            check_eq({tag, "_data"}, data_o, wdata);
            check_eq({tag, "_busy_rsp_valid"}, {31'd0, rsp_valid_o}, 32'd0);
            if (k == delay) begin
                ack_i = 1'b1;
                if (we_o) slv_mem[addr_o[5:2]] = data_o;
                else      data_i = slv_mem[addr_o[5:2]];
            end
            tick;
            ack_i  = 1'b0;
            data_i = 32'hDEAD_BEEF;
        end
        check_eq({tag, "_rsp_valid"}, {31'd0, rsp_valid_o}, 32'd1);
        check_eq({tag, "_req_drop"}, {31'd0, req_o}, 32'd0);
        check_eq({tag, "_rsp_err"}, {31'd0, rsp_err_o}, 32'd0);
        check_eq({tag, "_rsp_rdata"}, rsp_rdata_o, exp);
        check_eq({tag, "_resp_cmd_ready"}, {31'd0, cmd_ready_o}, 32'd0);
        for (int h = 0; h < hold; h++) begin
            cmd_valid_i = 1'b1;
            cmd_we_i    = 1'b0;
            cmd_addr_i  = 32'h8;
            tick;
            check_eq({tag, "_hold_valid"}, {31'd0, rsp_valid_o}, 32'd1);
            check_eq({tag, "_hold_rdata"}, rsp_rdata_o, exp);
            check_eq({tag, "_hold_cmd_ready"}, {31'd0, cmd_ready_o}, 32'd0);
            check_eq({tag, "_hold_req"}, {31'd0, req_o}, 32'd0);
        end
        rsp_ready_i = 1'b1;
        tick;
        cmd_valid_i = 1'b0;
        check_eq({tag, "_done_valid"}, {31'd0, rsp_valid_o}, 32'd0);
        check_eq({tag, "_done_cmd_ready"}, {31'd0, cmd_ready_o}, 32'd1);
        check_eq({tag, "_idle_req"}, {31'd0, req_o}, 32'd0);
    endtask

    logic        t6_we    [10];
    logic [31:0] t6_addr  [10];
    logic [31:0] t6_wdata [10];
    int          t6_delay [10];

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = 32'hA5A5_0001 + 32'(i);
            slv_mem[i] = 32'hA5A5_0001 + 32'(i);
        end
        t6_we = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        t6_addr = '{32'h08, 32'h08, 32'h20, 32'h04, 32'h20, 32'h3C, 32'h3C, 32'h10, 32'h00, 32'h00};
        t6_wdata = '{32'h1111_0008, 32'h0, 32'h2222_0020, 32'h0, 32'h0,
                     32'h3333_003C, 32'h0, 32'h0, 32'h4444_0000, 32'h0};
        t6_delay = '{2, 0, 4, 1, 3, 0, 4, 2, 1, 0};

        rst         = 1'b0;
        cmd_valid_i = 1'b0;
        cmd_we_i    = 1'b0;
        cmd_addr_i  = 32'd0;
        cmd_wdata_i = 32'd0;
        rsp_ready_i = 1'b1;
        data_i      = 32'hDEAD_BEEF;
        ack_i       = 1'b0;
        tick;
        tick;
        // Reset state: all outputs zero.
        check_eq("rst_cmd_ready", {31'd0, cmd_ready_o}, 32'd0);
        check_eq("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
        check_eq("rst_rdata", rsp_rdata_o, 32'd0);
        check_eq("rst_err", {31'd0, rsp_err_o}, 32'd0);
        check_eq("rst_req", {31'd0, req_o}, 32'd0);
        check_eq("rst_we", {31'd0, we_o}, 32'd0);
        check_eq("rst_addr", addr_o, 32'd0);
        check_eq("rst_data", data_o, 32'd0);
        rst = 1'b1;
        tick;
        check_eq("rel_cmd_ready", {31'd0, cmd_ready_o}, 32'd1);

        // 1: write with an immediate ack.
        do_cmd(1'b1, 32'h4, 32'h0000_5555, 0, 0, "t1");
        // 2: read with three wait cycles.
        do_cmd(1'b0, 32'h0, 32'h0, 3, 0, "t2");
        check_eq("t2_rdata_const", rsp_rdata_o, 32'hA5A5_0001);
        // 3: response back-pressure for five cycles; the read returns the value written in test 1.
        do_cmd(1'b0, 32'h4, 32'h0, 1, 5, "t3");
        check_eq("t3_rdata_const", rsp_rdata_o, 32'h0000_5555);
        do_cmd(1'b0, 32'h8, 32'h0, 0, 0, "t3_next");

`ifdef BUS_TIMEOUT_EN
        // 4: no ack ever, so the transaction gives up after 8 BUSY cycles.
        cmd_valid_i = 1'b1;
        cmd_we_i    = 1'b0;
        cmd_addr_i  = 32'hC;
        cmd_wdata_i = 32'h0;
        tick;
        cmd_valid_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check_eq("t4_to_req", {31'd0, req_o}, 32'd1);
            check_eq("t4_to_valid", {31'd0, rsp_valid_o}, 32'd0);
            tick;
        end
        check_eq("t4_to_req_drop", {31'd0, req_o}, 32'd0);
        check_eq("t4_to_valid_set", {31'd0, rsp_valid_o}, 32'd1);
        check_eq("t4_to_err", {31'd0, rsp_err_o}, 32'd1);
        check_eq("t4_to_rdata", rsp_rdata_o, 32'd0);
        tick;
        check_eq("t4_to_done", {31'd0, rsp_valid_o}, 32'd0);
        // The ack arrives on the 8th cycle and wins over the timeout.
        do_cmd(1'b0, 32'hC, 32'h0, 7, 0, "t4_ack8");
`else
        // Without the timeout feature a long wait must still end normally.
        do_cmd(1'b0, 32'hC, 32'h0, 20, 0, "t4_long");
`endif

        // 5: reset while BUSY.
        cmd_valid_i = 1'b1;
        cmd_we_i    = 1'b0;
        cmd_addr_i  = 32'h10;
        tick;
        cmd_valid_i = 1'b0;
        tick;
        check_eq("t5_busy_req", {31'd0, req_o}, 32'd1);
        rst = 1'b0;
        tick;
        check_eq("t5_rst_req", {31'd0, req_o}, 32'd0);
        check_eq("t5_rst_valid", {31'd0, rsp_valid_o}, 32'd0);
        rst = 1'b1;
        tick;
        check_eq("t5_rel_ready", {31'd0, cmd_ready_o}, 32'd1);
        check_eq("t5_rel_valid", {31'd0, rsp_valid_o}, 32'd0);
        do_cmd(1'b0, 32'h10, 32'h0, 1, 0, "t5_fresh");

        // 6: ten back-to-back commands checked against the reference memory.
        for (int i = 0; i < 10; i++) begin
            do_cmd(t6_we[i], t6_addr[i], t6_wdata[i], t6_delay[i], 0, $sformatf("t6_%0d", i));
        end
        check_eq("t6_last_rdata", rsp_rdata_o, 32'h4444_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
